// File: rtl/msrv32_gdef.sv
// msrv32 shared definitions for the PC pipeline.
// FSM encodings and stage-index helper constants.
package msrv32_gdef;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2
  } pc_state_t;

  localparam int unsigned MAX_DEPTH = 8;
  localparam int unsigned STAGE_IDX_W = 3;
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/msrv32_pc_stage.sv
// msrv32 PC pipeline stage: PC and valid register.
// Hold freezes both; clear drops valid but keeps the PC.
module msrv32_pc_stage #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] prev_pc,
  input  logic             prev_valid,
  output logic [WIDTH-1:0] pc,
  output logic             valid
);

  // Clear beats hold; otherwise shift from the previous stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= prev_pc;
      valid <= prev_valid;
    end
  end

endmodule

// File: rtl/msrv32_pc_pipe.sv
// msrv32 PC pipeline: boot FSM, stage 0 and
// a chain of shift stages carrying fetch PCs.
module msrv32_pc_pipe
  import msrv32_gdef::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  parameter logic [WIDTH-1:0] BOOT_ADDRESS = '0,
  parameter int unsigned BOOT_DELAY = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [WIDTH-1:0]       pc_mux_in,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic [WIDTH-1:0]       pc_out,
  output logic [DEPTH*WIDTH-1:0] pc_stage_out,
  output logic [DEPTH-1:0]       valid_stage_out,
  output logic                   misaligned_out,
  output logic                   boot_done_out
);

  localparam logic [CNT_W-1:0] DLY = CNT_W'(BOOT_DELAY);

  pc_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pc0;
  logic             valid0;
  logic             mis;
  logic             done;

  logic [WIDTH-1:0] pc_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic             run;
  logic             hold_up;
  logic             clear_up;

  assign run      = (state == RUN);
  assign hold_up  = !run || (stall_in && !flush_in);
  assign clear_up = run && flush_in;

  // Boot sequencing and stage 0; flush overrides stall in RUN.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= HOLD;
      cnt    <= '0;
      pc0    <= BOOT_ADDRESS;
      valid0 <= 1'b0;
      mis    <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == DLY) state <= BOOT;
          else            cnt   <= cnt + 1'b1;
        end
        BOOT: begin
          pc0    <= BOOT_ADDRESS;
          valid0 <= 1'b1;
          mis    <= |BOOT_ADDRESS[1:0];
          state  <= RUN;
          done   <= 1'b1;
        end
        RUN: begin
          if (flush_in || !stall_in) begin
            pc0    <= pc_mux_in;
            valid0 <= 1'b1;
            mis    <= |pc_mux_in[1:0];
          end
        end
        default: begin
          state <= HOLD;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_q[0]    = pc0;
  assign valid_q[0] = valid0;

  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    msrv32_pc_stage #(
      .WIDTH    (WIDTH),
      .RESET_PC (BOOT_ADDRESS)
    ) u_stage (
      .clk        (clk_in),
      .rst        (rst_in),
      .hold       (hold_up),
      .clear      (clear_up),
      .prev_pc    (pc_q[k-1]),
      .prev_valid (valid_q[k-1]),
      .pc         (pc_q[k]),
      .valid      (valid_q[k])
    );
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign pc_stage_out[k*WIDTH +: WIDTH] = pc_q[k];
  end

  assign pc_out          = pc0;
  assign valid_stage_out = valid_q;
  assign misaligned_out  = mis;
  assign boot_done_out   = done;

endmodule
